// File: rtl/freq_meter_100m.sv
// freq_meter_100m: measures an asynchronous slow input against clk_100M.
// Counts synchronized rising edges over a fixed gate window (freq) and the
// clk_100M distance between consecutive rising edges (period).
module freq_meter_100m #(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int unsigned CNT_W       = 27
) (
   input  logic             clk_100M,
   input  logic             clr,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             freq_valid,
   output logic             freq_ovf,
   output logic [CNT_W-1:0] period,
   output logic             period_valid
);

   localparam int unsigned      GateW    = $clog2(GATE_CYCLES);
   localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
   localparam logic [GateW-1:0] GateOne  = GateW'(1);
   localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e state_q, state_d;

   logic s1_q, s2_q, s3_q;
   logic rise;

   logic [GateW-1:0] gate_q, gate_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic             win_ovf_q, win_ovf_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic             armed_q, armed_d;

   logic [CNT_W-1:0] freq_q, freq_d;
   logic             freq_valid_q, freq_valid_d;
   logic             freq_ovf_q, freq_ovf_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             period_valid_q, period_valid_d;

   logic             run;
   logic             win_close;
   logic             edge_sat;
   logic [CNT_W-1:0] edge_next;
   logic             ovf_next;
   logic [CNT_W-1:0] per_plus;

   // Two-flop synchronizer plus history flop for rising-edge detection.
   always_ff @(posedge clk_100M) begin
      if (clr) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

   // Run/idle state register.
   always_ff @(posedge clk_100M) begin
      if (clr) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state follows the enable.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (en)  state_d = StRun;
         StRun:   if (!en) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign run       = (state_q == StRun);
   assign win_close = run & (gate_q == GateLast);
   assign edge_sat  = (edge_cnt_q == CntMax);
   assign edge_next = (rise & ~edge_sat) ? edge_cnt_q + CntOne : edge_cnt_q;
   assign ovf_next  = win_ovf_q | (rise & edge_sat);
   assign per_plus  = (per_cnt_q == CntMax) ? per_cnt_q : per_cnt_q + CntOne;

   // Counter and result next-state; idle clears counters and holds results.
   always_comb begin
      gate_d         = '0;
      edge_cnt_d     = '0;
      win_ovf_d      = 1'b0;
      per_cnt_d      = '0;
      armed_d        = 1'b0;
      freq_d         = freq_q;
      freq_ovf_d     = freq_ovf_q;
      freq_valid_d   = 1'b0;
      period_d       = period_q;
      period_valid_d = 1'b0;

      if (run) begin
         gate_d = win_close ? '0 : gate_q + GateOne;

         // An edge on the closing cycle still belongs to the closing window.
         if (win_close) begin
            freq_d       = edge_next;
            freq_ovf_d   = ovf_next;
            freq_valid_d = 1'b1;
         end else begin
            edge_cnt_d = edge_next;
            win_ovf_d  = ovf_next;
         end

         per_cnt_d = per_plus;
         armed_d   = armed_q;
         // The first edge after entering run only arms the period measurement.
         if (rise) begin
            if (armed_q) begin
               period_d       = per_plus;
               period_valid_d = 1'b1;
            end
            per_cnt_d = '0;
            armed_d   = 1'b1;
         end
      end
   end

   // Counter and result registers.
   always_ff @(posedge clk_100M) begin
      if (clr) begin
         gate_q         <= '0;
         edge_cnt_q     <= '0;
         win_ovf_q      <= 1'b0;
         per_cnt_q      <= '0;
         armed_q        <= 1'b0;
         freq_q         <= '0;
         freq_valid_q   <= 1'b0;
         freq_ovf_q     <= 1'b0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
      end else begin
         gate_q         <= gate_d;
         edge_cnt_q     <= edge_cnt_d;
         win_ovf_q      <= win_ovf_d;
         per_cnt_q      <= per_cnt_d;
         armed_q        <= armed_d;
         freq_q         <= freq_d;
         freq_valid_q   <= freq_valid_d;
         freq_ovf_q     <= freq_ovf_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
      end
   end

   assign freq         = freq_q;
   assign freq_valid   = freq_valid_q;
   assign freq_ovf     = freq_ovf_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;

endmodule

// File: tb/tb_freq_meter_100m.sv
// Bench for freq_meter_100m: two instances (short gate / wide counter and
// longer gate / 8-bit counter) checked every cycle against a cycle-index
// reference model, plus table vectors and directed corner sequences.
module tb_freq_meter_100m;

   localparam int unsigned GA = 1000;
   localparam int unsigned WA = 12;
   localparam int unsigned GB = 2000;
   localparam int unsigned WB = 8;

   logic clk_100M = 1'b0;
   always #5 clk_100M = ~clk_100M;

   logic       clr;
   logic [1:0] en;
   logic [1:0] sig;

   logic [WA-1:0] freq_a, period_a;
   logic          fv_a, ovf_a, pv_a;
   logic [WB-1:0] freq_b, period_b;
   logic          fv_b, ovf_b, pv_b;

   freq_meter_100m #(.GATE_CYCLES(GA), .CNT_W(WA)) dut_a (
      .clk_100M     (clk_100M),
      .clr          (clr),
      .en           (en[0]),
      .sig_in       (sig[0]),
      .freq         (freq_a),
      .freq_valid   (fv_a),
      .freq_ovf     (ovf_a),
      .period       (period_a),
      .period_valid (pv_a)
   );

   freq_meter_100m #(.GATE_CYCLES(GB), .CNT_W(WB)) dut_b (
      .clk_100M     (clk_100M),
      .clr          (clr),
      .en           (en[1]),
      .sig_in       (sig[1]),
      .freq         (freq_b),
      .freq_valid   (fv_b),
      .freq_ovf     (ovf_b),
      .period       (period_b),
      .period_valid (pv_b)
   );

   logic [31:0] g_freq[2], g_per[2];
   logic        g_fv[2], g_ovf[2], g_pv[2];
   assign g_freq[0] = 32'(freq_a);
   assign g_freq[1] = 32'(freq_b);
   assign g_per[0]  = 32'(period_a);
   assign g_per[1]  = 32'(period_b);
   assign g_fv[0]   = fv_a;
   assign g_fv[1]   = fv_b;
   assign g_ovf[0]  = ovf_a;
   assign g_ovf[1]  = ovf_b;
   assign g_pv[0]   = pv_a;
   assign g_pv[1]   = pv_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit known  = 0;

   int gcyc[2] = '{GA, GB};
   int maxv[2] = '{(1 << WA) - 1, (1 << WB) - 1};

   // Reference model state: sample history, window origin, unbounded counts.
   bit p1[2], p2[2], run_prev[2], armed[2];
   int win_start[2], last_rise[2], nedges[2];
   int ef[2], ep[2];
   bit eo[2], efv[2], epv[2];

   // Observed strobe captures.
   int fv_cnt[2], pv_cnt[2], last_fv_cyc[2];
   int freq_cap[2], per_cap[2], ovf_cap[2];

   // Stimulus generator state.
   bit manual[2], rnd[2];
   int hi_len[2], lo_len[2], ph_left[2];

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   // Compare outputs of this edge, then advance the model by one cycle.
   task automatic monitor();
      if (clr) known = 1;
      for (int d = 0; d < 2; d++) begin
         logic run, samp, rise;
         if (clr) begin
            ef[d] = 0; ep[d] = 0; eo[d] = 0; efv[d] = 0; epv[d] = 0;
         end
         if (known) begin
            chk($sformatf("d%0d freq", d), g_freq[d], ef[d]);
            chk($sformatf("d%0d freq_ovf", d), {31'd0, g_ovf[d]}, {31'd0, eo[d]});
            chk($sformatf("d%0d freq_valid", d), {31'd0, g_fv[d]}, {31'd0, efv[d]});
            chk($sformatf("d%0d period", d), g_per[d], ep[d]);
            chk($sformatf("d%0d period_valid", d), {31'd0, g_pv[d]}, {31'd0, epv[d]});
            if (g_fv[d] === 1'b1) begin
               fv_cnt[d]++;
               last_fv_cyc[d] = cyc;
               freq_cap[d] = int'(g_freq[d]);
               ovf_cap[d] = int'(g_ovf[d]);
            end
            if (g_pv[d] === 1'b1) begin
               pv_cnt[d]++;
               per_cap[d] = int'(g_per[d]);
            end
         end
         run  = en[d] && !clr;
         samp = clr ? 1'b0 : sig[d];
         rise = run && p1[d] && !p2[d];
         efv[d] = 0;
         epv[d] = 0;
         if (run) begin
            if (!run_prev[d]) begin
               win_start[d] = cyc;
               nedges[d] = 0;
               armed[d] = 0;
            end
            if (rise) begin
               nedges[d]++;
               if (armed[d]) begin
                  ep[d] = imin(cyc - last_rise[d], maxv[d]);
                  epv[d] = 1;
               end
               last_rise[d] = cyc;
               armed[d] = 1;
            end
            if ((cyc - win_start[d]) % gcyc[d] == gcyc[d] - 1) begin
               ef[d] = imin(nedges[d], maxv[d]);
               eo[d] = (nedges[d] > maxv[d]);
               efv[d] = 1;
               nedges[d] = 0;
            end
         end
         run_prev[d] = run;
         p2[d] = p1[d];
         p1[d] = samp;
      end
      cyc++;
   endtask

   task automatic gen(input int d);
      if (manual[d]) return;
      if (hi_len[d] == 0) begin
         sig[d] = 1'b0;
         ph_left[d] = 0;
      end else if (ph_left[d] <= 1) begin
         sig[d] = ~sig[d];
         ph_left[d] = rnd[d] ? int'($urandom_range(2, hi_len[d]))
                             : (sig[d] ? hi_len[d] : lo_len[d]);
      end else begin
         ph_left[d]--;
      end
   endtask

   // One clock: check just after the rising edge, drive on the falling edge.
   task automatic tick();
      @(posedge clk_100M);
      #1;
      monitor();
      @(negedge clk_100M);
      gen(0);
      gen(1);
   endtask

   typedef struct {
      int d;
      int hi;
      int lo;
      int exp_freq;
      int exp_ovf;
      int exp_period;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int d, n, k, r, base_fv, base_pv;
      vecs[0] = '{0, 5, 5, 100, 0, 10};
      vecs[1] = '{0, 2, 2, 250, 0, 4};
      vecs[2] = '{0, 3, 7, 100, 0, 10};
      vecs[3] = '{0, 25, 25, 20, 0, 50};
      vecs[4] = '{0, 0, 0, 0, 0, -1};
      vecs[5] = '{1, 2, 2, 255, 1, 4};
      vecs[6] = '{1, 0, 0, 0, 0, -1};
      vecs[7] = '{1, 150, 150, -1, 0, 255};

      clr = 1'b1;
      en  = 2'b00;
      sig = 2'b00;
      for (int i = 0; i < 2; i++) begin
         manual[i] = 0; rnd[i] = 0; hi_len[i] = 5; lo_len[i] = 5; ph_left[i] = 5;
      end
      tick();
      tick();
      clr = 1'b0;
      en  = 2'b11;

      // Steady-state patterns: the last strobe of each run reflects a full window.
      for (int i = 0; i < 8; i++) begin
         d = vecs[i].d;
         rnd[d] = 0;
         hi_len[d] = vecs[i].hi;
         lo_len[d] = vecs[i].lo;
         repeat (3 * gcyc[d] + 10) tick();
         if (vecs[i].exp_freq >= 0) begin
            chk($sformatf("vec%0d freq", i), freq_cap[d], vecs[i].exp_freq);
            chk($sformatf("vec%0d freq_ovf", i), ovf_cap[d], vecs[i].exp_ovf);
         end
         if (vecs[i].exp_period >= 0)
            chk($sformatf("vec%0d period", i), per_cap[d], vecs[i].exp_period);
      end

      // Edge landing exactly on the closing cycle of a freshly started window.
      manual[0] = 1;
      sig[0] = 1'b0;
      en[0] = 1'b0;
      repeat (3) tick();
      en[0] = 1'b1;
      repeat (998) tick();
      sig[0] = 1'b1;
      base_fv = fv_cnt[0];
      repeat (5) tick();
      chk("close edge strobe", fv_cnt[0], base_fv + 1);
      chk("close edge freq", freq_cap[0], 1);
      repeat (1000) tick();
      chk("after close freq", freq_cap[0], 0);
      sig[0] = 1'b0;

      // Enable drop mid-window, then a fresh window and a fresh period arm.
      en[0] = 1'b0;
      repeat (3) tick();
      en[0] = 1'b1;
      repeat (500) tick();
      en[0] = 1'b0;
      base_fv = fv_cnt[0];
      repeat (3) tick();
      en[0] = 1'b1;
      r = cyc;
      base_pv = pv_cnt[0];
      repeat (100) tick();
      sig[0] = 1'b1;
      repeat (15) tick();
      sig[0] = 1'b0;
      repeat (15) tick();
      sig[0] = 1'b1;
      repeat (10) tick();
      chk("drop pv count", pv_cnt[0], base_pv + 1);
      chk("drop period", per_cap[0], 30);
      sig[0] = 1'b0;
      repeat (865) tick();
      chk("drop fv count", fv_cnt[0], base_fv + 1);
      chk("drop fv timing", last_fv_cyc[0], r + 1000);

      // Synchronous clear mid-window.
      manual[0] = 0;
      hi_len[0] = 5;
      lo_len[0] = 5;
      repeat (400) tick();
      k = cyc;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("clr d%0d freq", i), g_freq[i], 0);
         chk($sformatf("clr d%0d period", i), g_per[i], 0);
         chk($sformatf("clr d%0d valids", i), {30'd0, g_fv[i], g_pv[i]}, 0);
         chk($sformatf("clr d%0d ovf", i), {31'd0, g_ovf[i]}, 0);
      end
      base_fv = fv_cnt[0];
      repeat (1005) tick();
      chk("clr fv count", fv_cnt[0], base_fv + 1);
      chk("clr fv timing", last_fv_cyc[0], k + 1001);
      chk("clr resumed freq", freq_cap[0], 100);

      // Randomized traffic, enable drops and occasional clears.
      for (int it = 0; it < 30; it++) begin
         d = int'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0: begin rnd[d] = 1; hi_len[d] = int'($urandom_range(2, 12)); end
            1: begin
               rnd[d] = 0;
               hi_len[d] = int'($urandom_range(2, 30));
               lo_len[d] = int'($urandom_range(2, 30));
            end
            default: begin rnd[d] = 0; hi_len[d] = 0; end
         endcase
         n = int'($urandom_range(50, 1000));
         for (int j = 0; j < n; j++) begin
            tick();
            if ($urandom_range(0, 399) == 0) begin
               en[d] = 1'b0;
               repeat ($urandom_range(1, 4)) tick();
               en[d] = 1'b1;
            end
            if ($urandom_range(0, 1999) == 0) begin
               clr = 1'b1;
               tick();
               clr = 1'b0;
            end
         end
      end
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
